// File: rtl/instruction_fetch_pkg.sv
// Shared pipeline constants, IF/ID register layout and fetch-step decode.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a; stall/redirect priority is resolved by fetch_op().
package instruction_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] PC_INCR           = 32'd4;

  // What the fetch stage does on a given clock edge, in priority order.
  typedef enum logic [1:0] {
    FETCH_RESET    = 2'd0,
    FETCH_REDIRECT = 2'd1,
    FETCH_STALL    = 2'd2,
    FETCH_SEQ      = 2'd3
  } fetch_op_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // Reset beats redirect beats stall; a redirect squashes even a stalled fetch
  // because the instruction sitting at PC is on the wrong path.
  function automatic fetch_op_t fetch_op(input logic reset,
                                         input logic redirect,
                                         input logic stall);
    if (reset)         return FETCH_RESET;
    else if (redirect) return FETCH_REDIRECT;
    else if (stall)    return FETCH_STALL;
    else               return FETCH_SEQ;
  endfunction

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: captures the fetched instruction or a bubble.
// Latency: one cycle from imem read data to if_id outputs.
// Backpressure: holds on FETCH_STALL; redirect/reset load a NOP bubble.
module instruction_fetch_if_id_reg
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  fetch_op_t   op,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  output if_id_t      if_id
);

  // Load, bubble or hold the IF/ID contents according to the fetch step.
  always_ff @(posedge clk) begin
    unique case (op)
      FETCH_RESET: begin
        if_id.instr    <= NOP_INSTR;
        if_id.pc       <= 32'h0;
        if_id.pc_plus4 <= 32'h0;
        if_id.valid    <= 1'b0;
      end
      FETCH_REDIRECT: begin
        // pc fields are loaded anyway; decode ignores them while valid is low
        if_id.instr    <= NOP_INSTR;
        if_id.pc       <= pc;
        if_id.pc_plus4 <= pc_plus4;
        if_id.valid    <= 1'b0;
      end
      FETCH_STALL: begin
        if_id <= if_id;
      end
      default: begin
        if_id.instr    <= instr;
        if_id.pc       <= pc;
        if_id.pc_plus4 <= pc_plus4;
        if_id.valid    <= 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, imem address, IF/ID register and fetch counter.
// Latency: instruction at PC reaches IF/ID one cycle later; redirect costs one bubble.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  fetch_op_t   op;
  if_id_t      if_id;

  // The memory sees the PC register directly; it aliases high addresses itself.
  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + PC_INCR;  // wraps naturally modulo 2^32
  assign op        = fetch_op(reset, redirect, stall);

  // Advance, redirect, hold or reset the program counter.
  always_ff @(posedge clk) begin
    unique case (op)
      FETCH_RESET:    pc_q <= RESET_PC;
      FETCH_REDIRECT: pc_q <= align_word(redirect_target);
      FETCH_STALL:    pc_q <= pc_q;
      default:        pc_q <= pc_plus4;
    endcase
  end

  // Count only real instructions entering IF/ID, i.e. sequential fetch steps.
  always_ff @(posedge clk) begin
    unique case (op)
      FETCH_RESET: fetch_count <= 32'h0;
      FETCH_SEQ:   fetch_count <= fetch_count + 32'd1;
      default:     fetch_count <= fetch_count;
    endcase
  end

  instruction_fetch_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .op       (op),
    .instr    (imem_instr),
    .pc       (pc_q),
    .pc_plus4 (pc_plus4),
    .if_id    (if_id)
  );

  assign if_id_instr    = if_id.instr;
  assign if_id_pc       = if_id.pc;
  assign if_id_pc_plus4 = if_id.pc_plus4;
  assign if_id_valid    = if_id.valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed vector table, hand-written
// corner sequence, and randomized run against a behavioural model.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr, imem_instr;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;
  logic        if_id_valid;

  logic [31:0] mem [256];

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_cnt;
  logic        m_valid;

  always #5 clk = ~clk;

  // 256-word instruction memory, aliased by address bits [9:2]
  assign imem_instr = mem[imem_addr[9:2]];

  instruction_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid),
    .fetch_count     (fetch_count)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ifpc;
    logic [31:0] ifpc4;
    logic        valid;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the rising edge.
  task automatic cycle(input logic r, input logic s, input logic d, input logic [31:0] t);
    reset = r; stall = s; redirect = d; redirect_target = t;
    @(posedge clk);
    #1;
  endtask

  // Model: next state derived from the functional rules, read before the edge.
  task automatic model_step(input logic r, input logic s, input logic d, input logic [31:0] t);
    logic [31:0] fetched;
    fetched = mem[m_pc[9:2]];
    if (r) begin
      m_pc = 32'h0; m_instr = NOP; m_ifpc = 0; m_ifpc4 = 0; m_valid = 0; m_cnt = 0;
    end else if (d) begin
      m_instr = NOP; m_valid = 0; m_ifpc = m_pc; m_ifpc4 = m_pc + 4;
      m_pc = t & ~32'h3;
    end else if (!s) begin
      m_instr = fetched; m_valid = 1; m_ifpc = m_pc; m_ifpc4 = m_pc + 4;
      m_cnt = m_cnt + 1;
      m_pc = m_pc + 4;
    end
  endtask

  function automatic logic [31:0] dmem(input int k);
    logic [31:0] w;
    w = 32'hA000_0000 | 32'(k);
    return w;
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;

    for (int k = 0; k < 256; k++) mem[k] = dmem(k);
    for (int k = 0; k < 4; k++) mem[k] = NOP;
    mem[4] = 32'h012A_5820;

    //          rst  stl  rdr  tgt            pc            instr          ifpc          ifpc4         v  cnt
    vecs[0]  = '{1, 0, 0, 32'h0,         32'h0,        NOP,           32'h0,        32'h0,        0, 0};
    vecs[1]  = '{0, 0, 0, 32'h0,         32'h4,        NOP,           32'h0,        32'h4,        1, 1};
    vecs[2]  = '{0, 0, 0, 32'h0,         32'h8,        NOP,           32'h4,        32'h8,        1, 2};
    vecs[3]  = '{0, 0, 0, 32'h0,         32'hC,        NOP,           32'h8,        32'hC,        1, 3};
    vecs[4]  = '{0, 0, 0, 32'h0,         32'h10,       NOP,           32'hC,        32'h10,       1, 4};
    vecs[5]  = '{0, 0, 0, 32'h0,         32'h14,       32'h012A5820,  32'h10,       32'h14,       1, 5};
    vecs[6]  = '{0, 1, 0, 32'h0,         32'h14,       32'h012A5820,  32'h10,       32'h14,       1, 5};
    vecs[7]  = '{0, 1, 0, 32'h0,         32'h14,       32'h012A5820,  32'h10,       32'h14,       1, 5};
    vecs[8]  = '{0, 1, 0, 32'h0,         32'h14,       32'h012A5820,  32'h10,       32'h14,       1, 5};
    vecs[9]  = '{0, 0, 0, 32'h0,         32'h18,       32'hA0000005,  32'h14,       32'h18,       1, 6};
    vecs[10] = '{0, 0, 1, 32'h10,        32'h10,       NOP,           32'h18,       32'h1C,       0, 6};
    vecs[11] = '{0, 0, 1, 32'h7,         32'h4,        NOP,           32'h10,       32'h14,       0, 6};
    vecs[12] = '{0, 0, 0, 32'h0,         32'h8,        NOP,           32'h4,        32'h8,        1, 7};
    vecs[13] = '{0, 1, 1, 32'h18,        32'h18,       NOP,           32'h8,        32'hC,        0, 7};
    vecs[14] = '{0, 0, 0, 32'h0,         32'h1C,       32'hA0000006,  32'h18,       32'h1C,       1, 8};
    vecs[15] = '{0, 0, 1, 32'hFFFFFFFC,  32'hFFFFFFFC, NOP,           32'h1C,       32'h20,       0, 8};
    vecs[16] = '{0, 0, 0, 32'h0,         32'h0,        32'hA00000FF,  32'hFFFFFFFC, 32'h0,        1, 9};
    vecs[17] = '{0, 0, 1, 32'h20,        32'h20,       NOP,           32'h0,        32'h4,        0, 9};
    vecs[18] = '{0, 1, 0, 32'h0,         32'h20,       NOP,           32'h0,        32'h4,        0, 9};
    vecs[19] = '{1, 1, 0, 32'h0,         32'h0,        NOP,           32'h0,        32'h0,        0, 0};
    vecs[20] = '{0, 0, 0, 32'h0,         32'h4,        NOP,           32'h0,        32'h4,        1, 1};

    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      cycle(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].tgt);
      chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].pc);
      chk($sformatf("vec%0d if_id_instr", i), if_id_instr, vecs[i].instr);
      chk($sformatf("vec%0d if_id_pc", i), if_id_pc, vecs[i].ifpc);
      chk($sformatf("vec%0d if_id_pc_plus4", i), if_id_pc_plus4, vecs[i].ifpc4);
      chk($sformatf("vec%0d if_id_valid", i), 32'(if_id_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d fetch_count", i), fetch_count, vecs[i].cnt);
    end

    // High address aliases into the memory without masking the PC itself.
    cycle(0, 0, 1, 32'h0000_0416);
    chk("alias addr", imem_addr, 32'h0000_0414);
    chk("alias bubble valid", 32'(if_id_valid), 32'h0);
    cycle(0, 0, 0, 32'h0);
    chk("alias instr", if_id_instr, 32'hA000_0005);
    chk("alias if_pc", if_id_pc, 32'h0000_0414);
    chk("alias next pc", imem_addr, 32'h0000_0418);
    chk("alias count", fetch_count, 32'd2);

    // Randomized run against the behavioural model.
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    model_step(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      logic        r, s, d;
      logic [31:0] t;
      r = ($urandom_range(0, 31) == 0);
      d = ($urandom_range(0, 5) == 0);
      s = ($urandom_range(0, 3) == 0);
      t = $urandom;
      model_step(r, s, d, t);
      cycle(r, s, d, t);
      chk("rnd imem_addr", imem_addr, m_pc);
      chk("rnd if_id_instr", if_id_instr, m_instr);
      chk("rnd if_id_pc", if_id_pc, m_ifpc);
      chk("rnd if_id_pc_plus4", if_id_pc_plus4, m_ifpc4);
      chk("rnd if_id_valid", 32'(if_id_valid), 32'(m_valid));
      chk("rnd fetch_count", fetch_count, m_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded by reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013: bubble encoding placed in IF/ID on flush and reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 stall  input  1  hazard-unit hold request for PC and IF/ID.
REQ-006 redirect  input  1  taken branch/jump resolved downstream; squashes the current fetch.
REQ-007 redirect_target  input  32  new PC accompanying redirect.
REQ-008 imem_addr  output  32  fetch address driven to the instruction memory (word index = bits [9:2]).
REQ-009 imem_instr  input  32  combinational instruction memory read data for imem_addr, same cycle.
REQ-010 if_id_instr  output  32  registered instruction to decode.
REQ-011 if_id_pc  output  32  registered address of if_id_instr.
REQ-012 if_id_pc_plus4  output  32  registered if_id_pc + 4.
REQ-013 if_id_valid  output  1  if_id_instr is a real fetched instruction, not a bubble.
REQ-014 fetch_count  output  32  number of instructions accepted into IF/ID since reset.

Function
REQ-015 imem_addr SHALL equal the PC register combinationally; no other logic SHALL be on that path.
REQ-016 The PC register SHALL update once per cycle with priority: reset > redirect > stall > sequential.
REQ-017 Sequential: PC <= PC + 4, modulo 2^32 (32'hFFFFFFFC wraps to 32'h00000000).
REQ-018 Redirect: PC <= {redirect_target[31:2], 2'b00}; the low two bits SHALL be forced to zero.
REQ-019 Stall without redirect: PC SHALL hold.
REQ-020 IF/ID on sequential cycle: if_id_instr <= imem_instr, if_id_pc <= PC, if_id_pc_plus4 <= PC + 4, if_id_valid <= 1.
REQ-021 IF/ID on redirect: if_id_instr <= NOP_INSTR, if_id_valid <= 0; if_id_pc and if_id_pc_plus4 SHALL be loaded as in REQ-020 (don't-care to downstream).
REQ-022 IF/ID on stall without redirect: all IF/ID outputs SHALL hold.
REQ-023 Redirect and stall asserted together: redirect SHALL win for both PC and IF/ID (the fetched instruction is on the wrong path).
REQ-024 fetch_count SHALL increment by 1 exactly on cycles where if_id_valid is loaded with 1, SHALL wrap modulo 2^32, and SHALL hold otherwise.
REQ-025 Fetch-to-decode latency SHALL be one cycle: the instruction at PC appears on if_id_instr the cycle after PC is presented.
REQ-026 Redirect-to-first-target-instruction latency SHALL be two cycles with exactly one bubble.
REQ-027 Addresses at or above 32'h400 SHALL alias into the 256-word memory via bits [9:2]; this block SHALL not trap them.

Reset
REQ-028 While reset is high at a rising clk: PC <= RESET_PC, if_id_instr <= NOP_INSTR, if_id_pc <= 0, if_id_pc_plus4 <= 0, if_id_valid <= 0, fetch_count <= 0.
REQ-029 Reset SHALL override stall and redirect in the same cycle.
REQ-030 Reset asserted mid-stream SHALL discard the in-flight IF/ID contents; the first cycle after deassertion fetches RESET_PC.

Structure
REQ-031 RESET_PC default, NOP_INSTR default, and PC increment constant 4 SHALL reside in the shared pipeline package with the other pipeline constants.
REQ-032 No sub-module is required; the IF/ID register MAY be split out as if_id_reg if the decode stage reuses it.

Verification
REQ-033 Reset then 4 free-running cycles, memory[0..3] = NOP, memory[4] = 32'h012A5820 -> imem_addr 0,4,8,C,10; if_id_instr = 32'h012A5820 with if_id_pc = 32'h10 one cycle after PC = 32'h10; fetch_count = 5.
REQ-034 stall high for 3 cycles while PC = 32'h14 -> PC and IF/ID held for all 3 cycles, fetch_count unchanged; fetch resumes at 32'h14.
REQ-035 redirect with target 32'h00000007 while PC = 32'h10 -> next PC = 32'h04, if_id_valid = 0 with NOP_INSTR for one cycle, then if_id_pc = 32'h04.
REQ-036 redirect and stall together, target 32'h18 -> PC = 32'h18, IF/ID bubbled, fetch_count not incremented.
REQ-037 Force PC to 32'hFFFFFFFC via redirect, then free-run -> next PC = 32'h00000000; if_id_pc_plus4 = 32'h00000000 for that fetch.
REQ-038 reset asserted for 1 cycle during a stall with PC = 32'h20 -> PC = RESET_PC, if_id_valid = 0, fetch_count = 0 on the following cycle.
